imm_extend_pipe: RTL and testbench

Parametrised, registered immediate extender for the CPU datapath. Widens an `IN_W`-bit immediate to `OUT_W` bits in one of four modes: sign, zero, upper-load or branch-offset. Inputs and outputs use valid/ready handshakes. A two-entry elastic buffer (main plus skid register) gives full throughput and keeps results in order when the downstream stage stalls. It sits between instruction decode and the ALU/branch-adder operand muxes.

---
 rtl/imm_extend_pipe.sv | 130 +++++++++++++
 tb/tb_imm_extend_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Registered immediate extender that sits between instruction decode and the
//   ALU/branch-adder operand muxes. It widens an IN_W-bit immediate to OUT_W bits
//   in sign, zero, upper-load or branch-offset mode. A two-entry elastic buffer
//   (main + skid) gives full throughput with in-order results under backpressure.
//
// Parameters
//   IN_W     : input immediate width
//   OUT_W    : output width, must be >= IN_W + SHIFT_BR
//   SHIFT_BR : left shift applied in branch mode
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   valid_i  : data_i/mode_i carry a request
//   ready_o  : a request is accepted this cycle (registered, state only)
//   data_i   : raw immediate
//   mode_i   : 00 sign, 01 zero, 10 upper, 11 branch
//   valid_o  : data_o carries a result
//   ready_i  : downstream takes the result this cycle
//   data_o   : extended immediate
module imm_extend_pipe #(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 32,
    parameter int unsigned SHIFT_BR = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o
);

    localparam int unsigned ExtW = OUT_W - IN_W;

    if (OUT_W < IN_W + SHIFT_BR) begin : g_bad_params
        $error("imm_extend_pipe: OUT_W must be >= IN_W + SHIFT_BR");
    end

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            r_state;
    logic              r_valid;
    logic              r_ready;
    logic [OUT_W-1:0]  r_main;
    logic [OUT_W-1:0]  r_skid;

    logic signed [IN_W-1:0] w_in_s;
    logic [OUT_W-1:0]       w_sext;
    logic [OUT_W-1:0]       w_zext;
    logic [OUT_W-1:0]       w_result;
    logic                   w_accept;
    logic                   w_pop;

    // Extension arithmetic; signed size-cast performs the sign extension.
    assign w_in_s = data_i;
    assign w_sext = OUT_W'(w_in_s);
    assign w_zext = OUT_W'(data_i);

    always_comb begin
        w_result = w_sext;
        unique case (mode_i)
            2'b00: w_result = w_sext;
            2'b01: w_result = w_zext;
            2'b10: w_result = w_zext << ExtW;
            2'b11: w_result = w_sext << SHIFT_BR;
            default: w_result = w_sext;
        endcase
    end

    assign w_accept = valid_i & r_ready;
    assign w_pop    = r_valid & ready_i;

    // State plus registered handshake outputs; ready_o never sees ready_i
    // combinationally, it only changes with the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StEmpty;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        r_main  <= w_result;
                        r_valid <= 1'b1;
                        r_state <= StOne;
                    end
                end
                StOne: begin
                    if (w_accept && !w_pop) begin
                        r_skid  <= w_result;
                        r_ready <= 1'b0;
                        r_state <= StFull;
                    end else if (w_pop && !w_accept) begin
                        r_valid <= 1'b0;
                        r_state <= StEmpty;
                    end else if (w_pop && w_accept) begin
                        // Pass-through: popped value leaves, new one takes main.
                        r_main <= w_result;
                    end
                end
                StFull: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_skid  <= '0;
                        r_ready <= 1'b1;
                        r_state <= StOne;
                    end
                end
                default: begin
                    r_state <= StEmpty;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign data_o  = r_main;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_i;
    logic [1:0]  mode_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;

    logic        v_valid_i;
    logic        v_ready_o;
    logic [7:0]  v_data_i;
    logic [1:0]  v_mode_i;
    logic        v_valid_o;
    logic        v_ready_i;
    logic [15:0] v_data_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q [$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHIFT_BR(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .SHIFT_BR(1)) dut_v (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (v_valid_i),
        .ready_o (v_ready_o),
        .data_i  (v_data_i),
        .mode_i  (v_mode_i),
        .valid_o (v_valid_o),
        .ready_i (v_ready_i),
        .data_o  (v_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
        case (m)
            2'b00:   return {{16{d[15]}}, d};
            2'b01:   return {16'h0000, d};
            2'b10:   return {d, 16'h0000};
            default: return {{14{d[15]}}, d, 2'b00};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle: what is accepted/popped at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    chk("sb_data", data_o, sb_q.pop_front());
                end
            end
            if (valid_i && ready_o) sb_q.push_back(model(data_i, mode_i));
        end
    end

    logic [15:0] m_d [5] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h0001};
    logic [1:0]  m_m [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [31:0] m_e [5] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC,
                             32'h00000004};

    logic [7:0]  v_d [4] = '{8'h80, 8'h80, 8'h12, 8'h80};
    logic [1:0]  v_m [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
    logic [15:0] v_e [4] = '{16'hFF80, 16'hFF00, 16'h1200, 16'h0080};

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0; mode_i = '0;
        v_valid_i = 1'b0; v_ready_i = 1'b1; v_data_i = '0; v_mode_i = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        chk("rst_data_o", data_o, 32'd0);

        // Modes, one cycle after accept
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; data_i = m_d[i]; mode_i = m_m[i];
            step();
            valid_i = 1'b0;
            chk("mode_valid", 32'(valid_o), 32'd1);
            chk($sformatf("mode_%0d", i), data_o, m_e[i]);
            step();
        end
        chk("mode_drain_valid", 32'(valid_o), 32'd0);

        // Backpressure: fill main and skid, hold a third request at the input
        ready_i = 1'b0;
        valid_i = 1'b1; data_i = 16'h0011; mode_i = 2'b00;
        step();
        chk("bp_ready_one", 32'(ready_o), 32'd1);
        chk("bp_data_first", data_o, 32'h00000011);
        data_i = 16'h0022;
        step();
        chk("bp_ready_full", 32'(ready_o), 32'd0);
        data_i = 16'h0033;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_data", data_o, 32'h00000011);
            chk("bp_hold_ready", 32'(ready_o), 32'd0);
            chk("bp_hold_valid", 32'(valid_o), 32'd1);
        end
        ready_i = 1'b1;
        step();
        chk("bp_pop_second", data_o, 32'h00000022);
        chk("bp_ready_back", 32'(ready_o), 32'd1);
        step();
        valid_i = 1'b0;
        chk("bp_held_req", data_o, 32'h00000033);
        step();
        chk("bp_empty", 32'(valid_o), 32'd0);

        // Streaming 64 back-to-back in zero mode
        for (int i = 0; i < 64; i++) begin
            valid_i = 1'b1; data_i = 16'(i); mode_i = 2'b01;
            step();
            chk("stream_ready", 32'(ready_o), 32'd1);
            chk("stream_data", data_o, 32'(i));
        end
        valid_i = 1'b0;
        step();
        chk("stream_drain", 32'(valid_o), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset from FULL; request during the reset cycle is dropped
        ready_i = 1'b0;
        valid_i = 1'b1; data_i = 16'h0044; mode_i = 2'b00;
        step();
        data_i = 16'h0055;
        step();
        chk("full_before_rst", 32'(ready_o), 32'd0);
        rst = 1'b1; data_i = 16'h0066;
        step();
        rst = 1'b0; valid_i = 1'b0;
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_ready", 32'(ready_o), 32'd1);
        chk("mid_rst_data", data_o, 32'd0);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_stale", 32'(valid_o), 32'd0);
        end
        valid_i = 1'b1; data_i = 16'h0077; mode_i = 2'b01;
        step();
        valid_i = 1'b0;
        chk("post_rst_fresh", data_o, 32'h00000077);
        step();

        // Parameter variant IN_W=8 OUT_W=16 SHIFT_BR=1
        for (int i = 0; i < 4; i++) begin
            v_valid_i = 1'b1; v_data_i = v_d[i]; v_mode_i = v_m[i];
            step();
            v_valid_i = 1'b0;
            chk("var_valid", 32'(v_valid_o), 32'd1);
            chk($sformatf("var_mode_%0d", i), 32'(v_data_o), 32'(v_e[i]));
            step();
        end
        chk("var_drain", 32'(v_valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
